// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one single-port bus slave among NUM_MASTERS requesters.
// Optional ack-wait timeout is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_MASTERS-1:0]             m_req,
  input  logic [NUM_MASTERS-1:0]             m_write,
  input  logic [NUM_MASTERS*ADDR_W-1:0]      m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0]      m_wdata,
  input  logic [NUM_MASTERS*(DATA_W/8)-1:0]  m_strobe,
  output logic [NUM_MASTERS-1:0]             m_ack,
  output logic [DATA_W-1:0]                  m_rdata,
  output logic                               m_err,
  output logic                               s_valid,
  output logic                               s_write,
  output logic [ADDR_W-1:0]                  s_addr,
  output logic [DATA_W-1:0]                  s_wdata,
  output logic [DATA_W/8-1:0]                s_strobe,
  input  logic                               s_ack,
  input  logic [DATA_W-1:0]                  s_rdata,
  output logic [$clog2(NUM_MASTERS)-1:0]     grant_id
);

  localparam int IDW = $clog2(NUM_MASTERS);
  localparam int SW  = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q;
  logic [IDW-1:0]         ptr_q;
  logic [IDW-1:0]         ptr_d;
  logic [IDW-1:0]         grant_q;
  logic                   write_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [SW-1:0]          strobe_q;
  logic                   valid_q;
  logic [NUM_MASTERS-1:0] ack_q;
  logic [DATA_W-1:0]      rdata_q;

  logic                   pickValid;
  logic [IDW-1:0]         pickIdx;
  logic [IDW:0]           cand;
  logic [NUM_MASTERS-1:0] ackOneHot;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [CNTW-1:0]        wait_q;
  logic                   err_q;
`endif

  // Search from the pointer upward with wrap; the extra bit absorbs ptr+k before the wrap.
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NUM_MASTERS)) begin
        cand = cand - (IDW+1)'(NUM_MASTERS);
      end
      if (!pickValid && m_req[cand[IDW-1:0]]) begin
        pickValid = 1'b1;
        pickIdx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    ptr_d = '0;
    if (grant_q != IDW'(NUM_MASTERS - 1)) begin
      ptr_d = grant_q + 1'b1;
    end
    ackOneHot = NUM_MASTERS'(1) << grant_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      strobe_q <= '0;
      valid_q  <= 1'b0;
      ack_q    <= '0;
      rdata_q  <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
      wait_q   <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (pickValid) begin
            grant_q  <= pickIdx;
            write_q  <= m_write[pickIdx];
            addr_q   <= m_addr[pickIdx*ADDR_W +: ADDR_W];
            wdata_q  <= m_wdata[pickIdx*DATA_W +: DATA_W];
            strobe_q <= m_strobe[pickIdx*SW +: SW];
            valid_q  <= 1'b1;
            state_q  <= BUSY;
`ifdef BUS_ARB_TIMEOUT_EN
            wait_q   <= '0;
`endif
          end
        end
        BUSY: begin
          if (s_ack) begin
            rdata_q <= s_rdata;
            ack_q   <= ackOneHot;
            valid_q <= 1'b0;
            ptr_q   <= ptr_d;
            state_q <= DONE;
`ifdef BUS_ARB_TIMEOUT_EN
            err_q   <= 1'b0;
          end else if (wait_q == CNTW'(TIMEOUT - 1)) begin
            rdata_q <= '0;
            ack_q   <= ackOneHot;
            err_q   <= 1'b1;
            valid_q <= 1'b0;
            ptr_q   <= ptr_d;
            state_q <= DONE;
          end else begin
            wait_q  <= wait_q + 1'b1;
`endif
          end
        end
        // Dead cycle lets the acked master drop its request before re-arbitration.
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_ack    = ack_q;
  assign m_rdata  = rdata_q;
  assign s_valid  = valid_q;
  assign s_write  = write_q;
  assign s_addr   = addr_q;
  assign s_wdata  = wdata_q;
  assign s_strobe = strobe_q;
  assign grant_id = grant_q;
`ifdef BUS_ARB_TIMEOUT_EN
  assign m_err    = err_q;
`else
  assign m_err    = 1'b0;
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed self-checking bench for bus_rr_arbiter with three masters and TIMEOUT=4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_bus_rr_arbiter;

  localparam int N = 3;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    m_req, m_write;
  logic [N*32-1:0] m_addr, m_wdata;
  logic [N*4-1:0]  m_strobe;
  logic [N-1:0]    m_ack;
  logic [31:0]     m_rdata;
  logic            m_err;
  logic            s_valid, s_write;
  logic [31:0]     s_addr, s_wdata;
  logic [3:0]      s_strobe;
  logic            s_ack;
  logic [31:0]     s_rdata;
  logic [1:0]      grant_id;

  int checks = 0;
  int errors = 0;

  bus_rr_arbiter #(.NUM_MASTERS(N), .ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .m_req(m_req), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata), .m_strobe(m_strobe),
    .m_ack(m_ack), .m_rdata(m_rdata), .m_err(m_err),
    .s_valid(s_valid), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata), .s_strobe(s_strobe),
    .s_ack(s_ack), .s_rdata(s_rdata), .grant_id(grant_id)
  );

  always #5 clock = ~clock;

  task automatic setMaster(input int idx, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
    m_write[idx]          = wr;
    m_addr[idx*32 +: 32]  = addr;
    m_wdata[idx*32 +: 32] = wdata;
    m_strobe[idx*4 +: 4]  = strb;
  endtask

  task automatic test_reset;
    reset = 1'b1; m_req = '0; m_write = '0; m_addr = '0; m_wdata = '0; m_strobe = '0;
    s_ack = 1'b0; s_rdata = '0;
    repeat (2) @(negedge clock);
    if (m_ack !== 3'b000) begin $display("[TB] FAIL rst_m_ack got %b want 000", m_ack); errors++; end checks++;
    if (m_rdata !== 32'h0) begin $display("[TB] FAIL rst_m_rdata got %h want 0", m_rdata); errors++; end checks++;
    if (m_err !== 1'b0) begin $display("[TB] FAIL rst_m_err got %b want 0", m_err); errors++; end checks++;
    if (s_valid !== 1'b0) begin $display("[TB] FAIL rst_s_valid got %b want 0", s_valid); errors++; end checks++;
    if ({s_write, s_addr, s_wdata, s_strobe} !== 69'h0) begin
      $display("[TB] FAIL rst_s_bus got %b/%h/%h/%b want zeros", s_write, s_addr, s_wdata, s_strobe); errors++;
    end checks++;
    if (grant_id !== 2'd0) begin $display("[TB] FAIL rst_grant_id got %0d want 0", grant_id); errors++; end checks++;
    reset = 1'b0;
  endtask

  task automatic test_single_read;
    setMaster(0, 1'b0, 32'h1000, 32'h0, 4'h0);
    m_req = 3'b001;
    @(negedge clock);
    if (s_valid !== 1'b1) begin $display("[TB] FAIL rd_s_valid got %b want 1", s_valid); errors++; end checks++;
    if (s_addr !== 32'h1000) begin $display("[TB] FAIL rd_s_addr got %h want 1000", s_addr); errors++; end checks++;
    if (s_write !== 1'b0) begin $display("[TB] FAIL rd_s_write got %b want 0", s_write); errors++; end checks++;
    if (grant_id !== 2'd0) begin $display("[TB] FAIL rd_grant got %0d want 0", grant_id); errors++; end checks++;
    if (m_ack !== 3'b000) begin $display("[TB] FAIL rd_early_ack got %b want 000", m_ack); errors++; end checks++;
    @(negedge clock);
    if (s_valid !== 1'b1 || m_ack !== 3'b000) begin
      $display("[TB] FAIL rd_wait got valid=%b ack=%b want 1/000", s_valid, m_ack); errors++;
    end checks++;
    s_ack = 1'b1; s_rdata = 32'hDEADBEEF;
    @(negedge clock);
    if (m_ack !== 3'b001) begin $display("[TB] FAIL rd_m_ack got %b want 001", m_ack); errors++; end checks++;
    if (m_rdata !== 32'hDEADBEEF) begin $display("[TB] FAIL rd_m_rdata got %h want deadbeef", m_rdata); errors++; end checks++;
    if (m_err !== 1'b0) begin $display("[TB] FAIL rd_m_err got %b want 0", m_err); errors++; end checks++;
    if (s_valid !== 1'b0) begin $display("[TB] FAIL rd_valid_drop got %b want 0", s_valid); errors++; end checks++;
    s_ack = 1'b0; m_req = '0;
    @(negedge clock);
    if (m_ack !== 3'b000) begin $display("[TB] FAIL rd_ack_pulse got %b want 000", m_ack); errors++; end checks++;
  endtask

  // Master 1 write held stable while masters 0 and 2 start requesting mid-transfer.
  task automatic test_write_hold;
    setMaster(1, 1'b1, 32'h20, 32'h55AA, 4'b0011);
    m_req = 3'b010;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      if (s_valid !== 1'b1 || s_write !== 1'b1 || grant_id !== 2'd1) begin
        $display("[TB] FAIL wr_ctrl[%0d] got valid=%b write=%b grant=%0d want 1/1/1", c, s_valid, s_write, grant_id); errors++;
      end checks++;
      if (s_addr !== 32'h20 || s_wdata !== 32'h55AA || s_strobe !== 4'b0011) begin
        $display("[TB] FAIL wr_data[%0d] got %h/%h/%b want 20/55aa/0011", c, s_addr, s_wdata, s_strobe); errors++;
      end checks++;
      if (m_ack !== 3'b000) begin $display("[TB] FAIL wr_early_ack[%0d] got %b want 000", c, m_ack); errors++; end checks++;
      if (c == 0) begin
        setMaster(0, 1'b0, 32'hBAD0, 32'hFFFF, 4'hF);
        setMaster(2, 1'b1, 32'hBAD2, 32'hEEEE, 4'hC);
        m_req = 3'b111;
      end
      if (c == 2) s_ack = 1'b1;
    end
    @(negedge clock);
    if (m_ack !== 3'b010) begin $display("[TB] FAIL wr_m_ack got %b want 010", m_ack); errors++; end checks++;
    if (s_valid !== 1'b0) begin $display("[TB] FAIL wr_valid_drop got %b want 0", s_valid); errors++; end checks++;
    s_ack = 1'b0; m_req = '0;
    @(negedge clock);
    if (m_ack !== 3'b000 || s_valid !== 1'b0) begin
      $display("[TB] FAIL wr_after got ack=%b valid=%b want 000/0", m_ack, s_valid); errors++;
    end checks++;
  endtask

  // Masters 0 and 1 request together; slave acks in the first BUSY cycle.
  task automatic test_alternate;
    int expOrder[4] = '{0, 1, 0, 1};
    int acks = 0;
    int lastCyc = 0;
    setMaster(0, 1'b0, 32'hA000, 32'h0, 4'h0);
    setMaster(1, 1'b0, 32'hA100, 32'h0, 4'h0);
    m_req = 3'b011;
    for (int cyc = 1; cyc <= 40 && acks < 4; cyc++) begin
      @(negedge clock);
      if (m_ack !== 3'b000) begin
        if (m_ack !== (3'b001 << expOrder[acks])) begin
          $display("[TB] FAIL alt_ack[%0d] got %b want %b", acks, m_ack, 3'b001 << expOrder[acks]); errors++;
        end checks++;
        if (acks > 0) begin
          if (cyc - lastCyc !== 3) begin
            $display("[TB] FAIL alt_spacing[%0d] got %0d want 3", acks, cyc - lastCyc); errors++;
          end checks++;
        end
        lastCyc = cyc;
        acks++;
        if (acks == 4) m_req = '0;
      end
      s_ack = s_valid;
    end
    if (acks !== 4) begin $display("[TB] FAIL alt_count got %0d want 4", acks); errors++; end checks++;
    @(negedge clock);
    s_ack = 1'b0;
  endtask

  // Pointer is 2 here; a spurious ack must neither pulse m_ack nor capture rdata.
  task automatic test_spurious_ack;
    @(negedge clock);
    s_ack = 1'b1; s_rdata = 32'h12345678;
    @(negedge clock);
    s_ack = 1'b0;
    if (m_ack !== 3'b000 || s_valid !== 1'b0) begin
      $display("[TB] FAIL sp_idle got ack=%b valid=%b want 000/0", m_ack, s_valid); errors++;
    end checks++;
    @(negedge clock);
    if (m_ack !== 3'b000) begin $display("[TB] FAIL sp_ack got %b want 000", m_ack); errors++; end checks++;
    if (m_rdata !== 32'hDEADBEEF) begin $display("[TB] FAIL sp_rdata got %h want deadbeef", m_rdata); errors++; end checks++;
    setMaster(2, 1'b0, 32'h300, 32'h0, 4'h0);
    m_req = 3'b100;
    @(negedge clock);
    if (s_valid !== 1'b1 || grant_id !== 2'd2 || s_addr !== 32'h300) begin
      $display("[TB] FAIL sp_grant got valid=%b grant=%0d addr=%h want 1/2/300", s_valid, grant_id, s_addr); errors++;
    end checks++;
    s_ack = 1'b1; s_rdata = 32'hCAFE0002;
    @(negedge clock);
    if (m_ack !== 3'b100 || m_rdata !== 32'hCAFE0002) begin
      $display("[TB] FAIL sp_m_ack got %b/%h want 100/cafe0002", m_ack, m_rdata); errors++;
    end checks++;
    s_ack = 1'b0; m_req = '0;
    @(negedge clock);
  endtask

  task automatic test_no_ack;
    setMaster(0, 1'b0, 32'h4000, 32'h0, 4'h0);
    m_req = 3'b001;
`ifdef BUS_ARB_TIMEOUT_EN
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      if (s_valid !== 1'b1 || m_ack !== 3'b000) begin
        $display("[TB] FAIL to_wait[%0d] got valid=%b ack=%b want 1/000", c, s_valid, m_ack); errors++;
      end checks++;
    end
    @(negedge clock);
    if (m_ack !== 3'b001 || m_err !== 1'b1) begin
      $display("[TB] FAIL to_ack got ack=%b err=%b want 001/1", m_ack, m_err); errors++;
    end checks++;
    if (m_rdata !== 32'h0 || s_valid !== 1'b0) begin
      $display("[TB] FAIL to_rdata got rdata=%h valid=%b want 0/0", m_rdata, s_valid); errors++;
    end checks++;
    s_ack = 1'b1; s_rdata = 32'h0BADF00D; m_req = '0;
    @(negedge clock);
    s_ack = 1'b0;
    if (m_ack !== 3'b000) begin $display("[TB] FAIL to_late_ack got %b want 000", m_ack); errors++; end checks++;
    @(negedge clock);
    if (m_ack !== 3'b000 || s_valid !== 1'b0) begin
      $display("[TB] FAIL to_after got ack=%b valid=%b want 000/0", m_ack, s_valid); errors++;
    end checks++;
`else
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (s_valid !== 1'b1 || m_ack !== 3'b000) begin
        $display("[TB] FAIL wait_forever[%0d] got valid=%b ack=%b want 1/000", c, s_valid, m_ack); errors++;
      end checks++;
      if (c == 20) begin s_ack = 1'b1; s_rdata = 32'h0BADF00D; end
    end
    @(negedge clock);
    if (m_ack !== 3'b001 || m_err !== 1'b0 || m_rdata !== 32'h0BADF00D) begin
      $display("[TB] FAIL slow_ack got %b/%b/%h want 001/0/0badf00d", m_ack, m_err, m_rdata); errors++;
    end checks++;
    s_ack = 1'b0; m_req = '0;
    @(negedge clock);
    if (m_ack !== 3'b000) begin $display("[TB] FAIL slow_after got %b want 000", m_ack); errors++; end checks++;
`endif
  endtask

  // Pointer is 1, so master 1 wins; reset mid-BUSY must restart arbitration from master 0.
  task automatic test_reset_mid_busy;
    setMaster(0, 1'b0, 32'h500, 32'h0, 4'h0);
    setMaster(1, 1'b0, 32'h600, 32'h0, 4'h0);
    m_req = 3'b011;
    @(negedge clock);
    if (grant_id !== 2'd1 || s_valid !== 1'b1 || s_addr !== 32'h600) begin
      $display("[TB] FAIL rb_grant got grant=%0d valid=%b addr=%h want 1/1/600", grant_id, s_valid, s_addr); errors++;
    end checks++;
    #2 reset = 1'b1;
    #1;
    if (s_valid !== 1'b0 || m_ack !== 3'b000 || grant_id !== 2'd0) begin
      $display("[TB] FAIL rb_abort got valid=%b ack=%b grant=%0d want 0/000/0", s_valid, m_ack, grant_id); errors++;
    end checks++;
    @(negedge clock);
    if (s_valid !== 1'b0 || m_ack !== 3'b000) begin
      $display("[TB] FAIL rb_held got valid=%b ack=%b want 0/000", s_valid, m_ack); errors++;
    end checks++;
    reset = 1'b0;
    @(negedge clock);
    if (grant_id !== 2'd0 || s_valid !== 1'b1 || s_addr !== 32'h500 || m_ack !== 3'b000) begin
      $display("[TB] FAIL rb_regrant got grant=%0d valid=%b addr=%h ack=%b want 0/1/500/000", grant_id, s_valid, s_addr, m_ack); errors++;
    end checks++;
    s_ack = 1'b1;
    @(negedge clock);
    if (m_ack !== 3'b001) begin $display("[TB] FAIL rb_ack got %b want 001", m_ack); errors++; end checks++;
    s_ack = 1'b0; m_req = '0;
    @(negedge clock);
  endtask

  // From a fresh reset with all masters requesting, grants rotate 0,1,2,0,1,2.
  task automatic test_fairness;
    int acks = 0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < N; i++) setMaster(i, 1'b0, 32'hF000 + i, 32'h0, 4'h0);
    m_req = 3'b111;
    for (int cyc = 1; cyc <= 60 && acks < 6; cyc++) begin
      @(negedge clock);
      if (m_ack !== 3'b000) begin
        if (m_ack !== (3'b001 << (acks % N)) || grant_id !== 2'(acks % N)) begin
          $display("[TB] FAIL fair[%0d] got ack=%b grant=%0d want %b/%0d", acks, m_ack, grant_id, 3'b001 << (acks % N), acks % N); errors++;
        end checks++;
        acks++;
        if (acks == 6) m_req = '0;
      end
      s_ack = s_valid;
    end
    if (acks !== 6) begin $display("[TB] FAIL fair_count got %0d want 6", acks); errors++; end checks++;
    s_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_hold();
    test_alternate();
    test_spurious_ack();
    test_no_ack();
    test_reset_mid_busy();
    test_fairness();
    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
